// File: rtl/grn_bus_pkg.sv
// Shared definitions for the tagged result bus: widths, FSM encoding and grant sources.
package grn_bus_pkg;

    localparam int ID_WIDTH      = 6;
    localparam int PAYLOAD_WIDTH = 376;
    localparam int BUS_WIDTH     = PAYLOAD_WIDTH + ID_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_LOCAL = 1'b0,
        GRANT_CHAIN = 1'b1
    } grant_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (local FIFO vs. upstream chain).
// The priority pointer only moves when a grant is actually issued.
module rr_arbiter2
    import grn_bus_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_req_local,
    input  logic i_req_chain,
    output logic o_gnt_local,
    output logic o_gnt_chain
);

    grant_t r_last;

    always_comb begin
        o_gnt_local = 1'b0;
        o_gnt_chain = 1'b0;
        if (i_en) begin
            if (i_req_local && i_req_chain) begin
                o_gnt_chain = (r_last == GRANT_LOCAL);
                o_gnt_local = (r_last == GRANT_CHAIN);
            end else begin
                o_gnt_chain = i_req_chain;
                o_gnt_local = i_req_local;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_last <= GRANT_LOCAL;
        else if (o_gnt_chain)
            r_last <= GRANT_CHAIN;
        else if (o_gnt_local)
            r_last <= GRANT_LOCAL;
    end

endmodule

// File: rtl/control_fifo_data_out.sv
// Return-path merge: pops local results, tags them with the core ID and
// interleaves them with upstream chain words onto a single-slot output bus.
module control_fifo_data_out
    import grn_bus_pkg::*;
#(
    parameter int ID            = 0,
    parameter int ID_WIDTH      = grn_bus_pkg::ID_WIDTH,
    parameter int PAYLOAD_WIDTH = grn_bus_pkg::PAYLOAD_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic                              i_fifo_out_empty,
    input  logic [PAYLOAD_WIDTH-1:0]          i_fifo_out_data,
    output logic                              o_fifo_out_re,
    input  logic                              i_chain_in_valid,
    input  logic [PAYLOAD_WIDTH+ID_WIDTH-1:0] i_chain_in_data,
    output logic                              o_chain_in_ready,
    output logic                              o_data_out_valid,
    output logic [PAYLOAD_WIDTH+ID_WIDTH-1:0] o_data_out,
    input  logic                              i_data_out_ready,
    input  logic                              i_local_done,
    input  logic                              i_chain_done_in,
    output logic                              o_done_out,
    output logic [31:0]                       o_sent_count
);

    localparam logic [ID_WIDTH-1:0] ID_TAG = ID_WIDTH'(ID);

    state_t                              r_state;
    state_t                              w_next;
    logic                                r_valid;
    logic [PAYLOAD_WIDTH+ID_WIDTH-1:0]   r_data;
    logic                                r_done;
    logic [31:0]                         r_cnt;
    logic                                w_slot_free;
    logic                                w_arb_en;
    logic                                w_gnt_local;
    logic                                w_gnt_chain;

    assign w_slot_free = ~r_valid | i_data_out_ready;
    assign w_arb_en    = (r_state == ST_ARB) & i_start & w_slot_free;

    rr_arbiter2 u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (w_arb_en),
        .i_req_local (~i_fifo_out_empty),
        .i_req_chain (i_chain_in_valid),
        .o_gnt_local (w_gnt_local),
        .o_gnt_chain (w_gnt_chain)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (i_start) w_next = ST_ARB;
            ST_ARB:     if (!i_start) w_next = ST_IDLE;
                        else if (w_gnt_local) w_next = ST_RD_WAIT;
            ST_RD_WAIT: w_next = i_start ? ST_ARB : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_fifo_out_re    = 1'b0;
        o_chain_in_ready = 1'b0;
        if (r_state == ST_ARB) begin
            o_fifo_out_re    = w_gnt_local;
            o_chain_in_ready = w_gnt_chain;
        end
    end

    // The slot is always empty in RD_WAIT: the read was only issued when the
    // slot was free, so any previous word transferred on that same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (o_chain_in_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_chain_in_data;
        end else if (r_state == ST_RD_WAIT) begin
            r_valid <= 1'b1;
            r_data  <= {i_fifo_out_data, ID_TAG};
            r_cnt   <= r_cnt + 32'd1;
        end else if (i_data_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_done <= 1'b0;
        else
            r_done <= i_local_done & i_chain_done_in & i_fifo_out_empty & ~r_valid
                      & (r_state != ST_RD_WAIT) & ~i_chain_in_valid;
    end

    assign o_data_out_valid = r_valid;
    assign o_data_out       = r_data;
    assign o_done_out       = r_done;
    assign o_sent_count     = r_cnt;

endmodule
